// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port SDRAM burst arbiter.
// Holds FSM state encodings, default widths and a small port-select helper.
// No logic of its own; imported by the arbiter top.
package sdram_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH  = 24;
    localparam int DEF_BURST_WIDTH = 10;
    localparam int DEF_DQ_WIDTH    = 16;
    localparam int DEF_WATCHDOG    = 1023;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } arb_state_e;

    function automatic logic [1:0] port_oh(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr2.sv
// Two-requester round-robin pick: the port not granted most recently wins a tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt_oh
);

    always_comb begin
        gnt_oh = 2'b00;
        if (req0 && req1) begin
            gnt_oh = last_gnt ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt_oh = 2'b01;
        end else if (req1) begin
            gnt_oh = 2'b10;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one sdram_core burst interface between two clients with round-robin grants.
// Latency: request sampled at t -> gnt and core request at t+1; finish at f -> done at f+1.
// Backpressure: clients hold req until gnt; only one burst owns the core at a time.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int APP_ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int APP_BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int SDR_DQ_WIDTH    = DEF_DQ_WIDTH,
    parameter int WATCHDOG_CYCLES = DEF_WATCHDOG
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_done,

    input  logic                       p0_req,
    input  logic                       p0_we,
    input  logic [APP_ADDR_WIDTH-1:0]  p0_addr,
    input  logic [APP_BURST_WIDTH-1:0] p0_len,
    input  logic [SDR_DQ_WIDTH-1:0]    p0_wdata,
    output logic                       p0_gnt,
    output logic                       p0_wdata_req,
    output logic [SDR_DQ_WIDTH-1:0]    p0_rdata,
    output logic                       p0_rdata_valid,
    output logic                       p0_done,

    input  logic                       p1_req,
    input  logic                       p1_we,
    input  logic [APP_ADDR_WIDTH-1:0]  p1_addr,
    input  logic [APP_BURST_WIDTH-1:0] p1_len,
    input  logic [SDR_DQ_WIDTH-1:0]    p1_wdata,
    output logic                       p1_gnt,
    output logic                       p1_wdata_req,
    output logic [SDR_DQ_WIDTH-1:0]    p1_rdata,
    output logic                       p1_rdata_valid,
    output logic                       p1_done,

    output logic                       wr_burst_req,
    output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
    output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
    output logic [SDR_DQ_WIDTH-1:0]    wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,

    output logic                       rd_burst_req,
    output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
    output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
    input  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data,
    input  logic                       rd_burst_data_valid,
    input  logic                       rd_burst_finish,

    output logic                       timeout_err
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    arb_state_e                 state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic [APP_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [APP_BURST_WIDTH-1:0] len_q, len_d;
    logic [WD_W-1:0]            wd_cnt_q, wd_cnt_d;
    logic [1:0]                 gnt_q, gnt_d;
    logic [1:0]                 done_q, done_d;
    logic                       wr_req_q, wr_req_d;
    logic                       rd_req_q, rd_req_d;
    logic                       timeout_q, timeout_d;
    logic                       zl_pend_q, zl_pend_d;

    logic [1:0]                 pick;
    logic                       sel_we;
    logic [APP_ADDR_WIDTH-1:0]  sel_addr;
    logic [APP_BURST_WIDTH-1:0] sel_len;
    logic                       wd_expire;

    rr_arbiter2 u_rr (
        .req0     (p0_req),
        .req1     (p1_req),
        .last_gnt (last_q),
        .gnt_oh   (pick)
    );

    assign sel_we    = pick[1] ? p1_we   : p0_we;
    assign sel_addr  = pick[1] ? p1_addr : p0_addr;
    assign sel_len   = pick[1] ? p1_len  : p0_len;
    assign wd_expire = (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wd_cnt_d  = wd_cnt_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        timeout_d = timeout_q;
        zl_pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A zero-length grant finishes here; no arbitration during its done cycle.
                if (zl_pend_q) begin
                    done_d = port_oh(owner_q);
                end else if (init_done && (pick != 2'b00)) begin
                    owner_d  = pick[1];
                    last_d   = pick[1];
                    addr_d   = sel_addr;
                    len_d    = sel_len;
                    gnt_d    = pick;
                    wd_cnt_d = '0;
                    if (sel_len == '0) begin
                        zl_pend_d = 1'b1;
                    end else if (sel_we) begin
                        state_d  = ST_WR_BUSY;
                        wr_req_d = 1'b1;
                    end else begin
                        state_d  = ST_RD_BUSY;
                        rd_req_d = 1'b1;
                    end
                end
            end
            ST_WR_BUSY: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (wr_burst_finish || wd_expire) begin
                    state_d   = ST_IDLE;
                    wr_req_d  = 1'b0;
                    done_d    = port_oh(owner_q);
                    timeout_d = timeout_q | ~wr_burst_finish;
                end
            end
            ST_RD_BUSY: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (rd_burst_finish || wd_expire) begin
                    state_d   = ST_IDLE;
                    rd_req_d  = 1'b0;
                    done_d    = port_oh(owner_q);
                    timeout_d = timeout_q | ~rd_burst_finish;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            wd_cnt_q  <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            timeout_q <= 1'b0;
            zl_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wd_cnt_q  <= wd_cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            timeout_q <= timeout_d;
            zl_pend_q <= zl_pend_d;
        end
    end

    assign p0_gnt        = gnt_q[0];
    assign p1_gnt        = gnt_q[1];
    assign p0_done       = done_q[0];
    assign p1_done       = done_q[1];
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_req  = rd_req_q;
    assign wr_burst_addr = addr_q;
    assign rd_burst_addr = addr_q;
    assign wr_burst_len  = len_q;
    assign rd_burst_len  = len_q;
    assign timeout_err   = timeout_q;

    // Strobes reach only the owner, and only while its channel is active.
    assign p0_wdata_req   = (state_q == ST_WR_BUSY) && !owner_q && wr_burst_data_req;
    assign p1_wdata_req   = (state_q == ST_WR_BUSY) &&  owner_q && wr_burst_data_req;
    assign p0_rdata_valid = (state_q == ST_RD_BUSY) && !owner_q && rd_burst_data_valid;
    assign p1_rdata_valid = (state_q == ST_RD_BUSY) &&  owner_q && rd_burst_data_valid;
    assign wr_burst_data  = (state_q != ST_WR_BUSY) ? '0 : (owner_q ? p1_wdata : p0_wdata);
    assign p0_rdata       = rd_burst_data;
    assign p1_rdata       = rd_burst_data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table plus multi-cycle sequences.
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int BW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, init_done;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [BW-1:0] p0_len, p1_len;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_wdata_req, p0_rdata_valid, p0_done;
    logic          p1_gnt, p1_wdata_req, p1_rdata_valid, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          wr_burst_req, rd_burst_req;
    logic [AW-1:0] wr_burst_addr, rd_burst_addr;
    logic [BW-1:0] wr_burst_len, rd_burst_len;
    logic [DW-1:0] wr_burst_data, rd_burst_data;
    logic          wr_burst_data_req, wr_burst_finish;
    logic          rd_burst_data_valid, rd_burst_finish;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .APP_ADDR_WIDTH (AW),
        .APP_BURST_WIDTH(BW),
        .SDR_DQ_WIDTH   (DW),
        .WATCHDOG_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_len(p0_len), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_wdata_req(p0_wdata_req), .p0_rdata(p0_rdata),
        .p0_rdata_valid(p0_rdata_valid), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_len(p1_len), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_wdata_req(p1_wdata_req), .p1_rdata(p1_rdata),
        .p1_rdata_valid(p1_rdata_valid), .p1_done(p1_done),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish(wr_burst_finish),
        .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish(rd_burst_finish),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        logic [1:0]    exp_gnt;
        logic          exp_wr;
        logic          exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt"},  {30'd0, p1_gnt, p0_gnt}, 32'd0);
        chk({name, "_done"}, {30'd0, p1_done, p0_done}, 32'd0);
        chk({name, "_req"},  {30'd0, wr_burst_req, rd_burst_req}, 32'd0);
        chk({name, "_addr"}, {8'd0, wr_burst_addr | rd_burst_addr}, 32'd0);
        chk({name, "_len"},  {22'd0, wr_burst_len | rd_burst_len}, 32'd0);
        chk({name, "_tmo"},  {31'd0, timeout_err}, 32'd0);
        chk({name, "_strb"}, {28'd0, p0_wdata_req, p1_wdata_req, p0_rdata_valid, p1_rdata_valid}, 32'd0);
        chk({name, "_wdat"}, {16'd0, wr_burst_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seen;

        vecs[0] = '{1'b0, 1'b1, 24'h000010, 10'd1,   2'b01, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 24'h000100, 10'd4,   2'b10, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 24'hABCDEF, 10'h3FF, 2'b10, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 10'd2,   2'b01, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 24'h000555, 10'd0,   2'b01, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 24'h000AAA, 10'd0,   2'b10, 1'b0, 1'b0};

        init_done = 0; p0_req = 0; p0_we = 0; p0_addr = '0; p0_len = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_len = '0; p1_wdata = '0;
        wr_burst_data_req = 0; wr_burst_finish = 0; rd_burst_data = '0;
        rd_burst_data_valid = 0; rd_burst_finish = 0;
        do_reset();
        chk_all_zero("reset");

        // Init gating
        p0_req = 1; p0_we = 1; p0_addr = 24'h5; p0_len = 10'd2;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (p0_gnt || p1_gnt || wr_burst_req) seen++;
        end
        chk("init_block", seen, 0);
        init_done = 1;
        cyc();
        chk("init_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("init_wrreq", {31'd0, wr_burst_req}, 32'd1);
        p0_req = 0;
        wr_burst_finish = 1;
        cyc();
        chk("init_done_pulse", {30'd0, p1_done, p0_done}, 32'd1);
        wr_burst_finish = 0;
        cyc();

        // Single-requester vector table
        for (int i = 0; i < 6; i++) begin
            p0_req = !vecs[i].port; p1_req = vecs[i].port;
            p0_we = vecs[i].we; p1_we = vecs[i].we;
            p0_addr = vecs[i].addr; p1_addr = vecs[i].addr;
            p0_len = vecs[i].len; p1_len = vecs[i].len;
            cyc();
            chk($sformatf("vec%0d_gnt", i), {30'd0, p1_gnt, p0_gnt}, {30'd0, vecs[i].exp_gnt});
            chk($sformatf("vec%0d_wrreq", i), {31'd0, wr_burst_req}, {31'd0, vecs[i].exp_wr});
            chk($sformatf("vec%0d_rdreq", i), {31'd0, rd_burst_req}, {31'd0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_addr", i), {8'd0, vecs[i].we ? wr_burst_addr : rd_burst_addr},
                {8'd0, vecs[i].addr});
            chk($sformatf("vec%0d_len", i), {22'd0, vecs[i].we ? wr_burst_len : rd_burst_len},
                {22'd0, vecs[i].len});
            p0_req = 0; p1_req = 0;
            if (vecs[i].len != '0) begin
                // finish on the other channel must be ignored
                if (vecs[i].we) rd_burst_finish = 1; else wr_burst_finish = 1;
                cyc();
                chk($sformatf("vec%0d_hold", i), {31'd0, wr_burst_req | rd_burst_req}, 32'd1);
                chk($sformatf("vec%0d_nodone", i), {30'd0, p1_done, p0_done}, 32'd0);
                wr_burst_finish = 0; rd_burst_finish = 0;
                if (vecs[i].we) wr_burst_finish = 1; else rd_burst_finish = 1;
            end
            cyc();
            chk($sformatf("vec%0d_done", i), {30'd0, p1_done, p0_done}, {30'd0, vecs[i].exp_gnt});
            chk($sformatf("vec%0d_reqlow", i), {30'd0, wr_burst_req, rd_burst_req}, 32'd0);
            wr_burst_finish = 0; rd_burst_finish = 0;
            cyc();
            chk($sformatf("vec%0d_donepulse", i), {30'd0, p1_done, p0_done}, 32'd0);
        end

        // Contention: both write, p0 first (p1 granted last), p1 two cycles after finish
        p0_req = 1; p0_we = 1; p0_addr = 24'h10; p0_len = 10'd1; p0_wdata = 16'h1111;
        p1_req = 1; p1_we = 1; p1_addr = 24'h20; p1_len = 10'd1; p1_wdata = 16'h2222;
        cyc();
        chk("cont_gnt0", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        chk("cont_addr0", {8'd0, wr_burst_addr}, 32'h10);
        p0_req = 0;
        wr_burst_data_req = 1;
        #1;
        chk("cont_wdata", {16'd0, wr_burst_data}, 32'h1111);
        chk("cont_wdreq", {30'd0, p1_wdata_req, p0_wdata_req}, 32'd1);
        wr_burst_data_req = 0;
        wr_burst_finish = 1;
        cyc();
        chk("cont_done0", {30'd0, p1_done, p0_done}, 32'd1);
        chk("cont_gap", {30'd0, p1_gnt, wr_burst_req}, 32'd0);
        wr_burst_finish = 0;
        cyc();
        chk("cont_gnt1", {30'd0, p1_gnt, p0_gnt}, 32'd2);
        chk("cont_addr1", {8'd0, wr_burst_addr}, 32'h20);
        p1_req = 0;
        wr_burst_data_req = 1;
        #1;
        chk("cont_wdata1", {16'd0, wr_burst_data}, 32'h2222);
        chk("cont_wdreq1", {30'd0, p1_wdata_req, p0_wdata_req}, 32'd2);
        wr_burst_data_req = 0;
        wr_burst_finish = 1;
        cyc();
        chk("cont_done1", {30'd0, p1_done, p0_done}, 32'd2);
        wr_burst_finish = 0;
        cyc();

        // Read routing to p1
        p1_req = 1; p1_we = 0; p1_addr = 24'h100; p1_len = 10'd4;
        cyc();
        chk("rd_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd2);
        p1_req = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            rd_burst_data = 16'hA0 + 16'(i);
            rd_burst_data_valid = 1;
            #1;
            if (p1_rdata_valid && !p0_rdata_valid && p1_rdata == 16'hA0 + 16'(i)) seen++;
            cyc();
        end
        chk("rd_valid_count", seen, 4);
        rd_burst_data_valid = 0;
        rd_burst_finish = 1;
        cyc();
        chk("rd_done", {30'd0, p1_done, p0_done}, 32'd2);
        chk("rd_reqlow", {31'd0, rd_burst_req}, 32'd0);
        rd_burst_finish = 0;
        cyc();

        // Watchdog expiry: 8 busy cycles with request high, then drop
        p0_req = 1; p0_we = 1; p0_addr = 24'h40; p0_len = 10'd3;
        cyc();
        chk("wd_gnt", {31'd0, p0_gnt}, 32'd1);
        p0_req = 0;
        seen = 1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (wr_burst_req) seen++;
        end
        chk("wd_busy_cycles", seen, 8);
        cyc();
        chk("wd_reqlow", {31'd0, wr_burst_req}, 32'd0);
        chk("wd_tmo", {31'd0, timeout_err}, 32'd1);
        chk("wd_done", {30'd0, p1_done, p0_done}, 32'd1);
        cyc(); cyc(); cyc();
        chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
        do_reset();
        chk("wd_rst_clear", {31'd0, timeout_err}, 32'd0);

        // Finish coinciding with expiry
        p0_req = 1; p0_we = 1; p0_addr = 24'h44; p0_len = 10'd3;
        cyc();
        p0_req = 0;
        for (int i = 0; i < 7; i++) cyc();
        wr_burst_finish = 1;
        cyc();
        wr_burst_finish = 0;
        chk("wdfin_done", {30'd0, p1_done, p0_done}, 32'd1);
        chk("wdfin_tmo", {31'd0, timeout_err}, 32'd0);
        chk("wdfin_reqlow", {31'd0, wr_burst_req}, 32'd0);
        cyc();

        // Reset mid-burst, then contention after release
        p1_req = 1; p1_we = 0; p1_addr = 24'h300; p1_len = 10'd8;
        cyc();
        chk("rst_gnt", {31'd0, rd_burst_req}, 32'd1);
        p1_req = 0;
        cyc();
        rst = 1;
        cyc();
        rd_burst_data_valid = 1; wr_burst_data_req = 1;
        #1;
        chk_all_zero("midrst");
        rd_burst_data_valid = 0; wr_burst_data_req = 0;
        rst = 0;
        p0_req = 1; p0_we = 1; p0_addr = 24'h50; p0_len = 10'd2;
        p1_req = 1; p1_we = 1; p1_addr = 24'h60; p1_len = 10'd2;
        cyc();
        chk("postrst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        chk("postrst_nodone", {30'd0, p1_done, p0_done}, 32'd0);
        chk("postrst_addr", {8'd0, wr_burst_addr}, 32'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
